oposta_matriz_seq: RTL and testbench

Sequential, parametrised successor to the combinational matrix negation unit. It latches a flattened DIM x DIM matrix of signed LARGURA-bit elements on a start pulse and processes VIAS elements per clock. Four element-wise unary modes are supported: pass, wrapping negate, saturating negate and saturating absolute value. It drives a registered result matrix, busy/done handshake and a sticky overflow flag, and sits beside the other matrix operation units under the coprocessor control FSM.

---
 rtl/oposta_matriz_seq_if.sv | 38 +++
 rtl/oposta_matriz_seq.sv | 143 ++++++++++++++
 tb/tb_oposta_matriz_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/oposta_matriz_seq_if.sv
// ---------------------------------------------------------------------------
// oposta_matriz_seq_if
// Handshake and data bundle of the sequential matrix negation unit.
//
// Signals:
//   iniciar         master -> slave  start request, taken only when idle
//   modo[1:0]       master -> slave  0 pass, 1 negate wrap, 2 negate sat,
//                                    3 abs sat; sampled with iniciar
//   matriz_entrada  master -> slave  flattened DIM x DIM source matrix,
//                                    element (coluna,linha) at
//                                    LARGURA*(linha + DIM*coluna)
//   matriz_saida    slave -> master  registered result, same layout
//   ocupado         slave -> master  high while beats are being processed
//   pronto          slave -> master  one-cycle done pulse
//   estouro         slave -> master  sticky overflow/saturation flag
// ---------------------------------------------------------------------------
interface oposta_matriz_seq_if #(
    parameter int LARGURA = 8,
    parameter int DIM     = 5
);
    logic                         iniciar;
    logic [1:0]                   modo;
    logic [LARGURA*DIM*DIM-1:0]   matriz_entrada;
    logic [LARGURA*DIM*DIM-1:0]   matriz_saida;
    logic                         ocupado;
    logic                         pronto;
    logic                         estouro;

    modport master (
        output iniciar, modo, matriz_entrada,
        input  matriz_saida, ocupado, pronto, estouro
    );

    modport slave (
        input  iniciar, modo, matriz_entrada,
        output matriz_saida, ocupado, pronto, estouro
    );
endinterface

// File: rtl/oposta_matriz_seq.sv
// ---------------------------------------------------------------------------
// oposta_matriz_seq
// Sequential element-wise unary operator on a DIM x DIM matrix of signed
// LARGURA-bit elements. A start latches the operands, then VIAS elements are
// processed per clock for NB = ceil(DIM*DIM/VIAS) beats, followed by a
// one-cycle done pulse.
//
// Ports:
//   clk    input  rising-edge clock
//   rst_n  input  asynchronous active-low reset
//   bus    slave  modport of oposta_matriz_seq_if (iniciar, modo,
//                 matriz_entrada in; matriz_saida, ocupado, pronto,
//                 estouro out)
// ---------------------------------------------------------------------------
module oposta_matriz_seq #(
    parameter int LARGURA = 8,
    parameter int DIM     = 5,
    parameter int VIAS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    oposta_matriz_seq_if.slave   bus
);
    localparam int N  = DIM * DIM;
    localparam int NB = (N + VIAS - 1) / VIAS;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    // Lane indices run up to NB*VIAS-1, which may exceed N-1 on the last beat.
    localparam int IW = $clog2(NB * VIAS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } estado_t;

    estado_t                estado_q;
    logic [LARGURA*N-1:0]   entrada_q;
    logic [LARGURA*N-1:0]   saida_q;
    logic [1:0]             modo_q;
    logic [CW-1:0]          beat_q;
    logic                   ocupado_q;
    logic                   pronto_q;
    logic                   estouro_q;

    // Returns {overflow, result} for one element.
    function automatic logic [LARGURA:0] opera(input logic [1:0] m,
                                               input logic [LARGURA-1:0] x);
        logic               is_min;
        logic [LARGURA-1:0] neg;
        logic [LARGURA-1:0] max_pos;
        logic [LARGURA:0]   r;
        is_min  = (x == {1'b1, {(LARGURA-1){1'b0}}});
        neg     = -x;
        max_pos = {1'b0, {(LARGURA-1){1'b1}}};
        case (m)
            2'd0:    r = {1'b0, x};
            // Two's complement negation of MIN wraps back onto MIN.
            2'd1:    r = {is_min, neg};
            2'd2:    r = {is_min, (is_min ? max_pos : neg)};
            default: r = x[LARGURA-1] ? {is_min, (is_min ? max_pos : neg)}
                                      : {1'b0, x};
        endcase
        return r;
    endfunction

    logic [VIAS-1:0]    lane_ok;
    logic [VIAS-1:0]    lane_ovf;
    logic [LARGURA-1:0] lane_res  [VIAS];
    int                 lane_base [VIAS];

    generate
        for (genvar gi = 0; gi < VIAS; gi++) begin : g_lane
            logic [IW-1:0]      idx;
            logic [IW-1:0]      sel;
            logic [LARGURA:0]   op;
            assign idx = IW'(beat_q) * IW'(VIAS) + IW'(gi);
            // Lanes past the last element on a partial beat never write.
            assign lane_ok[gi]   = (idx < IW'(N));
            // Parking unused lanes on element 0 keeps the read in range.
            assign sel           = lane_ok[gi] ? idx : '0;
            assign lane_base[gi] = int'(sel) * LARGURA;
            assign op            = opera(modo_q, entrada_q[lane_base[gi] +: LARGURA]);
            assign lane_res[gi]  = op[LARGURA-1:0];
            assign lane_ovf[gi]  = op[LARGURA];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= IDLE;
            entrada_q <= '0;
            saida_q   <= '0;
            modo_q    <= 2'd0;
            beat_q    <= '0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
            estouro_q <= 1'b0;
        end else begin
            case (estado_q)
                IDLE: begin
                    pronto_q <= 1'b0;
                    if (bus.iniciar) begin
                        entrada_q <= bus.matriz_entrada;
                        modo_q    <= bus.modo;
                        estouro_q <= 1'b0;
                        beat_q    <= '0;
                        ocupado_q <= 1'b1;
                        estado_q  <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < VIAS; i++) begin
                        if (lane_ok[i]) begin
                            saida_q[lane_base[i] +: LARGURA] <= lane_res[i];
                        end
                    end
                    estouro_q <= estouro_q | (|(lane_ovf & lane_ok));
                    if (beat_q == CW'(NB - 1)) begin
                        ocupado_q <= 1'b0;
                        pronto_q  <= 1'b1;
                        estado_q  <= DONE;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                DONE: begin
                    pronto_q <= 1'b0;
                    estado_q <= IDLE;
                end
                default: begin
                    ocupado_q <= 1'b0;
                    pronto_q  <= 1'b0;
                    estado_q  <= IDLE;
                end
            endcase
        end
    end

    assign bus.matriz_saida = saida_q;
    assign bus.ocupado      = ocupado_q;
    assign bus.pronto       = pronto_q;
    assign bus.estouro      = estouro_q;
endmodule

// File: tb/tb_oposta_matriz_seq.sv
// ---------------------------------------------------------------------------
// tb_oposta_matriz_seq
// Three instances: cfg0 DIM=5 VIAS=1, cfg1 DIM=5 VIAS=4, cfg2 DIM=3 VIAS=2.
// Expected results come from an integer-arithmetic model of the element rules.
// ---------------------------------------------------------------------------
module tb_oposta_matriz_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    oposta_matriz_seq_if #(.LARGURA(8), .DIM(5)) ia ();
    oposta_matriz_seq_if #(.LARGURA(8), .DIM(5)) ib ();
    oposta_matriz_seq_if #(.LARGURA(8), .DIM(3)) ic ();

    oposta_matriz_seq #(.LARGURA(8), .DIM(5), .VIAS(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    oposta_matriz_seq #(.LARGURA(8), .DIM(5), .VIAS(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    oposta_matriz_seq #(.LARGURA(8), .DIM(3), .VIAS(2)) u_c (.clk(clk), .rst_n(rst_n), .bus(ic));

    logic         ini   [3];
    logic [1:0]   mdo   [3];
    logic [199:0] min_v [3];
    logic [199:0] mout  [3];
    logic         oc [3];
    logic         pr [3];
    logic         es [3];

    assign ia.iniciar = ini[0]; assign ia.modo = mdo[0]; assign ia.matriz_entrada = min_v[0];
    assign ib.iniciar = ini[1]; assign ib.modo = mdo[1]; assign ib.matriz_entrada = min_v[1];
    assign ic.iniciar = ini[2]; assign ic.modo = mdo[2]; assign ic.matriz_entrada = min_v[2][71:0];
    assign mout[0] = ia.matriz_saida;
    assign mout[1] = ib.matriz_saida;
    assign mout[2] = {128'b0, ic.matriz_saida};
    assign oc[0] = ia.ocupado; assign pr[0] = ia.pronto; assign es[0] = ia.estouro;
    assign oc[1] = ib.ocupado; assign pr[1] = ib.pronto; assign es[1] = ib.estouro;
    assign oc[2] = ic.ocupado; assign pr[2] = ic.pronto; assign es[2] = ic.estouro;

    int dims [3] = '{5, 5, 3};
    int nbs  [3] = '{25, 7, 5};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Element rules applied with plain integer arithmetic.
    task automatic ref_mat(input int dim, input logic [1:0] m, input logic [199:0] a,
                           output logic [199:0] y, output logic ov);
        logic [7:0] b;
        int v;
        int r;
        y  = '0;
        ov = 1'b0;
        for (int e = 0; e < dim * dim; e++) begin
            b = a[e*8 +: 8];
            v = int'($signed(b));
            case (m)
                2'd0: r = v;
                2'd1: begin r = -v; if (r > 127) r = r - 256; end
                2'd2: begin r = -v; if (r > 127) r = 127; end
                default: begin r = (v < 0) ? -v : v; if (r > 127) r = 127; end
            endcase
            if (m != 2'd0 && v == -128) ov = 1'b1;
            y[e*8 +: 8] = r[7:0];
        end
    endtask

    function automatic logic [199:0] rand_mat(input bit no_min);
        logic [199:0] a;
        logic [7:0] b;
        for (int e = 0; e < 25; e++) begin
            b = 8'($urandom);
            if (no_min && b == 8'h80) b = 8'h81;
            a[e*8 +: 8] = b;
        end
        return a;
    endfunction

    // One operation on instance c; cycle k is sampled 1 time unit after edge k-1,
    // edge 0 being the start edge. poke > 0 re-pulses iniciar with different
    // operands in that cycle.
    task automatic run_op(input int c, input logic [1:0] m, input logic [199:0] a, input int poke);
        logic [199:0] y;
        logic ov;
        int nb, pc, np, ocup_bad, both;
        ref_mat(dims[c], m, a, y, ov);
        nb = nbs[c];
        @(negedge clk);
        ini[c] = 1'b1; mdo[c] = m; min_v[c] = a;
        @(posedge clk); #1;
        ini[c] = 1'b0;
        pc = 0; np = 0; ocup_bad = 0; both = 0;
        for (int cyc = 1; cyc <= nb + 4; cyc++) begin
            if (oc[c] !== (cyc <= nb)) ocup_bad++;
            if (oc[c] === 1'b1 && pr[c] === 1'b1) both++;
            if (pr[c] === 1'b1) begin
                np++;
                if (pc == 0) begin
                    pc = cyc;
                    chk("result", mout[c], y);
                    chk("estouro", 200'(es[c]), 200'(ov));
                end
            end
            if (cyc == poke) begin
                ini[c] = 1'b1; mdo[c] = ~m; min_v[c] = ~a;
            end else if (cyc == poke + 1) begin
                ini[c] = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("pronto_cycle", 200'(pc), 200'(nb + 1));
        chk("pronto_count", 200'(np), 200'(1));
        chk("ocupado_window", 200'(ocup_bad), 200'(0));
        chk("pronto_ocupado_overlap", 200'(both), 200'(0));
        $display("op cfg=%0d modo=%0d pronto_cycle=%0d estouro=%0b", c, m, pc, es[c]);
    endtask

    initial begin
        logic [199:0] a, b2, ya, yb;
        logic oa, ob;
        int np, nseen;

        for (int c = 0; c < 3; c++) begin
            ini[c] = 1'b0; mdo[c] = 2'd0; min_v[c] = '0;
        end
        #12;
        for (int c = 0; c < 3; c++) begin
            chk("reset_saida", mout[c], '0);
            chk("reset_flags", 200'({oc[c], pr[c], es[c]}), '0);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Wrapping negate with the reference corner elements.
        a = rand_mat(1'b0);
        a[31:0] = 32'h00_80_7F_01;
        run_op(0, 2'd1, a, 0);
        a = mout[0];
        chk("wrap_elems", 200'(a[31:0]), 200'(32'h00_80_81_FF));

        // Saturating negate, then abs with and without MIN.
        a = rand_mat(1'b0); a[15:0] = 16'h05_80;
        run_op(0, 2'd2, a, 0);
        a = mout[0];
        chk("neg_sat_elems", 200'(a[15:0]), 200'(16'hFB_7F));
        a = rand_mat(1'b0); a[15:0] = 16'h80_FB;
        run_op(0, 2'd3, a, 0);
        a = mout[0];
        chk("abs_sat_elems", 200'(a[15:0]), 200'(16'h7F_05));
        run_op(0, 2'd3, rand_mat(1'b1), 0);

        // Partial last beat.
        run_op(1, 2'd0, rand_mat(1'b0), 0);

        // Start and operand changes during RUN are ignored.
        run_op(0, 2'd1, rand_mat(1'b0), 5);

        // Back-to-back with iniciar held: one IDLE cycle separates operations,
        // so prontos land at NB+1 and 2*NB+3.
        a  = rand_mat(1'b0); a[15:8] = 8'h80;
        b2 = rand_mat(1'b1);
        ref_mat(3, 2'd1, a, ya, oa);
        ref_mat(3, 2'd3, b2, yb, ob);
        @(negedge clk);
        ini[2] = 1'b1; mdo[2] = 2'd1; min_v[2] = a;
        @(posedge clk); #1;
        mdo[2] = 2'd3; min_v[2] = b2;
        np = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (pr[2] === 1'b1) begin
                np++;
                if (np == 1) begin
                    chk("b2b_p1_cycle", 200'(cyc), 200'(6));
                    chk("b2b_p1_result", mout[2], ya);
                    chk("b2b_p1_estouro", 200'(es[2]), 200'(oa));
                end else if (np == 2) begin
                    chk("b2b_p2_cycle", 200'(cyc), 200'(13));
                    chk("b2b_p2_result", mout[2], yb);
                    chk("b2b_p2_estouro", 200'(es[2]), 200'(ob));
                    ini[2] = 1'b0;
                end
            end
            @(posedge clk); #1;
        end
        ini[2] = 1'b0;
        chk("b2b_pronto_count", 200'(np), 200'(2));
        $display("op b2b cfg=2 prontos=%0d", np);

        // Reset in the middle of RUN.
        a = rand_mat(1'b0); a[7:0] = 8'h80;
        @(negedge clk);
        ini[0] = 1'b1; mdo[0] = 2'd1; min_v[0] = a;
        @(posedge clk); #1;
        ini[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("pre_reset_busy", 200'({oc[0], es[0]}), 200'(2'b11));
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_reset_saida", mout[0], '0);
        chk("midrun_reset_flags", 200'({oc[0], pr[0], es[0]}), '0);
        @(negedge clk); rst_n = 1'b1;
        nseen = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk); #1;
            if (pr[0] === 1'b1 || oc[0] === 1'b1) nseen++;
        end
        chk("aborted_no_activity", 200'(nseen), '0);
        $display("op reset_mid cfg=0 activity_after=%0d", nseen);
        run_op(0, 2'd2, rand_mat(1'b0), 0);

        // Random operations across all configurations.
        for (int k = 0; k < 6; k++) begin
            run_op(k % 3, 2'($urandom_range(0, 3)), rand_mat(1'b0), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
